// File: rtl/clkgen_pkg.sv
// Shared types and constants for the NCO clock-enable generator.
`timescale 1ns/1ps
package clkgen_pkg;

  // Settle counter width and upper bound on channel count.
  localparam int SETTLE_CNT_W = 16;
  localparam int MAX_CH       = 8;
  localparam int CH_IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } clkgen_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [SETTLE_CNT_W-1:0] sat_inc(input logic [SETTLE_CNT_W-1:0] v);
    logic [SETTLE_CNT_W-1:0] r;
    r = (v == '1) ? v : v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clkgen_nco_ch.sv
// One NCO channel: phase accumulator, increment register, carry tick and
// square-wave output taken from the accumulator MSB.
`timescale 1ns/1ps
module clkgen_nco_ch
  import clkgen_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_phase,
  output logic             tick,
  output logic             outclk
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  // One extra bit captures the carry-out that becomes the next tick.
  assign sum = {1'b0, acc} + {1'b0, inc};

  // Accumulate every cycle; a write reloads phase/increment and kills any pending tick.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      inc  <= '0;
      tick <= 1'b0;
    end else if (wr_en) begin
      acc  <= wr_phase;
      inc  <= wr_inc;
      tick <= 1'b0;
    end else begin
      acc  <= sum[ACC_W-1:0];
      tick <= sum[ACC_W];
    end
  end

  assign outclk = acc[ACC_W-1];

endmodule

// File: rtl/clkgen_nco.sv
// Multi-channel NCO clock-enable generator with a lock sequencer.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_RESET   | held in reset; config port closed
// ST_SETTLE  | counting LOCK_CYCLES edges since entry or last in-range write
// ST_LOCKED  | settled; locked high; settle counter saturates
`timescale 1ns/1ps
module clkgen_nco
  import clkgen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   outclk,
  output logic                locked
);

  localparam logic [SETTLE_CNT_W-1:0] LOCK_LAST = SETTLE_CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_IDX_W:0]       NUM_CH_L  = (CH_IDX_W + 1)'(NUM_CH);

  clkgen_state_e             state, nxt_state;
  logic [SETTLE_CNT_W-1:0]   settle_cnt, nxt_cnt;
  logic                      wr_acc;
  logic                      ch_in_range;
  logic                      wr_in_range;
  logic [NUM_CH-1:0]         ch_wr;

  // Out-of-range channel writes are still handshaken but must not disturb the sequencer.
  assign wr_acc      = cfg_valid & cfg_ready;
  assign ch_in_range = ({1'b0, cfg_ch} < NUM_CH_L);
  assign wr_in_range = wr_acc & ch_in_range;

  // State, settle counter and registered lock flag.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ST_RESET;
      settle_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= nxt_state;
      settle_cnt <= nxt_cnt;
      locked     <= (nxt_state == ST_LOCKED);
    end
  end

  // Next-state, counter update and ready decode.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = settle_cnt;
    cfg_ready = 1'b0;
    case (state)
      ST_RESET: begin
        nxt_state = ST_SETTLE;
        nxt_cnt   = '0;
      end
      ST_SETTLE: begin
        cfg_ready = 1'b1;
        if (wr_in_range) begin
          nxt_cnt = '0;
        end else if (settle_cnt == LOCK_LAST) begin
          nxt_state = ST_LOCKED;
          nxt_cnt   = sat_inc(settle_cnt);
        end else begin
          nxt_cnt = sat_inc(settle_cnt);
        end
      end
      ST_LOCKED: begin
        cfg_ready = 1'b1;
        if (wr_in_range) begin
          nxt_state = ST_SETTLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = sat_inc(settle_cnt);
        end
      end
      default: begin
        nxt_state = ST_RESET;
        nxt_cnt   = '0;
      end
    endcase
  end

  // One channel per enable output; each sees only writes addressed to it.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_wr[c] = wr_in_range && (cfg_ch == CH_IDX_W'(c));

    clkgen_nco_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .refclk   (refclk),
      .rst      (rst),
      .wr_en    (ch_wr[c]),
      .wr_inc   (cfg_inc),
      .wr_phase (cfg_phase),
      .tick     (tick[c]),
      .outclk   (outclk[c])
    );
  end

endmodule

// File: tb/tb_clkgen_nco.sv
// Directed bench for clkgen_nco (NUM_CH=2, ACC_W=32, LOCK_CYCLES=16).
`timescale 1ns/1ps
module tb_clkgen_nco;

  logic        refclk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic [31:0] cfg_phase;
  logic [1:0]  tick;
  logic [1:0]  outclk;
  logic        locked;

  int total = 0;
  int bad   = 0;

  clkgen_nco #(
    .NUM_CH      (2),
    .ACC_W       (32),
    .LOCK_CYCLES (16)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .tick      (tick),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic cyc();
    @(negedge refclk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input logic v, input logic [2:0] ch, input logic [31:0] inc,
                        input logic [31:0] phase);
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_inc   = inc;
    cfg_phase = phase;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, t0, t1, rise;
    logic any_tick, any_out;

    rst = 1'b1;
    set_wr(1'b0, 3'd0, 32'd0, 32'd0);
    cyc();
    cyc();
    check("rst_ready",  64'(cfg_ready), 64'd0);
    check("rst_locked", 64'(locked),    64'd0);
    check("rst_tick",   64'(tick),      64'd0);
    check("rst_outclk", 64'(outclk),    64'd0);

    // Release; ready only after the first edge.
    rst = 1'b0;
    #2;
    check("pre_edge_ready", 64'(cfg_ready), 64'd0);
    cyc();
    check("settle_ready",  64'(cfg_ready), 64'd1);
    check("settle_locked", 64'(locked),    64'd0);
    n = 0;
    while (!locked && n < 40) begin
      cyc();
      n++;
    end
    check("lock_latency", 64'(n), 64'd16);

    // Out-of-range channel: accepted, no effect anywhere.
    set_wr(1'b1, 3'd5, 32'd1, 32'hFFFF_FFFF);
    check("oor_ready", 64'(cfg_ready), 64'd1);
    cyc();
    cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("oor_locked", 64'(locked), 64'd1);
      check("oor_tick",   64'(tick),   64'd0);
      check("oor_outclk", 64'(outclk), 64'd0);
      cyc();
    end

    // ch0 quarter-rate; write while locked drops lock at the accepting edge.
    set_wr(1'b1, 3'd0, 32'h4000_0000, 32'd0);
    cyc();
    cfg_valid = 1'b0;
    check("wr_locked_drop", 64'(locked), 64'd0);
    for (int k = 0; k < 10; k++) begin
      check("ch0_outclk", 64'(outclk[0]), 64'((k % 4) >= 2));
      check("ch0_tick",   64'(tick[0]),   64'((k > 0) && (k % 4 == 0)));
      check("ch0_settle_locked", 64'(locked), 64'd0);
      if (k == 9) set_wr(1'b1, 3'd1, 32'hCCCC_CCCD, 32'd0);
      cyc();
    end
    cfg_valid = 1'b0;

    // ch1 at 0.8 rate; the write at SETTLE cycle 10 restarts the lock count.
    check("ch1_wr_tick", 64'(tick[1]), 64'd0);
    t0 = 0;
    t1 = 0;
    rise = 0;
    for (int k = 1; k <= 5000; k++) begin
      cyc();
      if (tick[0]) t0++;
      if (tick[1]) t1++;
      if (locked && rise == 0) rise = k;
    end
    check("restart_lock", 64'(rise), 64'd16);
    check("ch1_ticks",    64'(t1),   64'd4000);
    check("ch0_ticks",    64'(t0),   64'd1250);
    check("locked_hold",  64'(locked), 64'd1);

    // Back-to-back writes to both channels; ch0 frozen with inc=0.
    set_wr(1'b1, 3'd0, 32'd0, 32'h8000_0000);
    cyc();
    check("b2b_ready", 64'(cfg_ready), 64'd1);
    set_wr(1'b1, 3'd1, 32'h4000_0000, 32'd0);
    cyc();
    cfg_valid = 1'b0;
    rise = 0;
    for (int k = 0; k <= 20; k++) begin
      check("b2b_outclk", 64'(outclk), 64'({((k % 4) >= 2), 1'b1}));
      check("b2b_tick",   64'(tick),   64'({((k > 0) && (k % 4 == 0)), 1'b0}));
      if (locked && rise == 0) rise = k;
      cyc();
    end
    check("b2b_lock", 64'(rise), 64'd16);

    // Short async reset between edges.
    #2;
    rst = 1'b1;
    #0.5;
    check("arst_outclk", 64'(outclk),    64'd0);
    check("arst_tick",   64'(tick),      64'd0);
    check("arst_locked", 64'(locked),    64'd0);
    check("arst_ready",  64'(cfg_ready), 64'd0);
    #0.5;
    rst = 1'b0;
    #1;
    check("arst_release_ready", 64'(cfg_ready), 64'd0);
    cyc();
    check("arst_settle_ready", 64'(cfg_ready), 64'd1);
    any_tick = 1'b0;
    any_out  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      any_tick = any_tick | (|tick);
      any_out  = any_out | (|outclk);
    end
    check("arst_no_tick", 64'(any_tick), 64'd0);
    check("arst_no_out",  64'(any_out),  64'd0);

    // Rewrite ch1 and see it run again.
    set_wr(1'b1, 3'd1, 32'h4000_0000, 32'hC000_0000);
    cyc();
    cfg_valid = 1'b0;
    check("rewr_outclk", 64'(outclk[1]), 64'd1);
    check("rewr_tick0",  64'(tick[1]),   64'd0);
    cyc();
    check("rewr_tick1",  64'(tick[1]),   64'd1);
    check("rewr_out1",   64'(outclk[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
